// File: rtl/i_cache.sv
// Direct-mapped instruction cache: one-cycle hit response, line refill from
// backing memory in ascending word order, whole-cache flush.
module i_cache #(
  parameter int ADDR_WIDTH     = 32,
  parameter int INSTR_WIDTH    = 32,
  parameter int NUM_LINES      = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_req_valid,
  input  logic [ADDR_WIDTH-1:0]  i_req_addr,
  output logic                   o_req_ready,
  output logic                   o_rsp_valid,
  output logic [INSTR_WIDTH-1:0] o_rsp_instr,
  input  logic                   i_flush,
  output logic                   o_mem_req_valid,
  output logic [ADDR_WIDTH-1:0]  o_mem_req_addr,
  input  logic                   i_mem_req_ready,
  input  logic                   i_mem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] i_mem_rsp_data
);

  localparam int OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int WORD_W = ADDR_WIDTH - 2;
  localparam int TAG_W  = WORD_W - OFF_W - IDX_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, MEM_REQ, REFILL} state_t;

  state_t                 state;
  logic [WORD_W-1:0]      req_word;
  logic [NUM_LINES-1:0]   valid;
  logic [OFF_W-1:0]       beat_cnt;
  logic                   flush_pending;
  logic [TAG_W-1:0]       tag_arr  [NUM_LINES];
  logic [INSTR_WIDTH-1:0] data_arr [NUM_LINES*WORDS_PER_LINE];

  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             hit;
  logic             last_beat;
  logic             unused_byte_bits;

  // The address is held as a word address; the byte offset never matters.
  assign unused_byte_bits = ^i_req_addr[1:0];

  assign req_off   = req_word[OFF_W-1:0];
  assign req_idx   = req_word[OFF_W +: IDX_W];
  assign req_tag   = req_word[WORD_W-1 : OFF_W+IDX_W];
  assign hit       = (state == LOOKUP) && valid[req_idx] && (tag_arr[req_idx] == req_tag);
  assign last_beat = (state == REFILL) && i_mem_rsp_valid &&
                     (beat_cnt == OFF_W'(WORDS_PER_LINE-1));

  assign o_req_ready     = !i_reset && ((state == IDLE) || hit);
  assign o_rsp_valid     = !i_reset && hit;
  assign o_rsp_instr     = o_rsp_valid ? data_arr[{req_idx, req_off}] : '0;
  assign o_mem_req_valid = !i_reset && (state == MEM_REQ);
  assign o_mem_req_addr  = {req_word[WORD_W-1:OFF_W], (OFF_W+2)'(0)};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= IDLE;
      req_word      <= '0;
      valid         <= '0;
      beat_cnt      <= '0;
      flush_pending <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_flush) valid <= '0;
          if (i_req_valid) begin
            req_word <= i_req_addr[ADDR_WIDTH-1:2];
            state    <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (i_flush) valid <= '0;
          if (hit) begin
            if (i_req_valid) begin
              req_word <= i_req_addr[ADDR_WIDTH-1:2];
              state    <= LOOKUP;
            end else begin
              state <= IDLE;
            end
          end else begin
            state <= MEM_REQ;
          end
        end
        MEM_REQ: begin
          if (i_flush) flush_pending <= 1'b1;
          if (i_mem_req_ready) begin
            beat_cnt <= '0;
            state    <= REFILL;
          end
        end
        REFILL: begin
          if (i_flush) flush_pending <= 1'b1;
          if (i_mem_rsp_valid) beat_cnt <= beat_cnt + 1'b1;
          // A flush seen during the refill also kills the line just fetched.
          if (last_beat) begin
            state         <= LOOKUP;
            flush_pending <= 1'b0;
            if (flush_pending || i_flush) valid <= '0;
            else                          valid[req_idx] <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset && (state == REFILL) && i_mem_rsp_valid)
      data_arr[{req_idx, beat_cnt}] <= i_mem_rsp_data;
    if (!i_reset && last_beat)
      tag_arr[req_idx] <= req_tag;
  end

endmodule

// File: tb/tb_i_cache.sv
// Directed self-checking bench for i_cache: misses, streaming hits, eviction,
// flushes, memory back-pressure and reset in the middle of a refill.
module tb_i_cache;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_req_valid;
  logic [31:0] i_req_addr;
  logic        o_req_ready;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_instr;
  logic        i_flush;
  logic        o_mem_req_valid;
  logic [31:0] o_mem_req_addr;
  logic        i_mem_req_ready;
  logic        i_mem_rsp_valid;
  logic [31:0] i_mem_rsp_data;

  int checks = 0;
  int failures = 0;

  i_cache #(
    .ADDR_WIDTH(32), .INSTR_WIDTH(32), .NUM_LINES(64), .WORDS_PER_LINE(4)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .o_req_ready(o_req_ready),
    .o_rsp_valid(o_rsp_valid), .o_rsp_instr(o_rsp_instr), .i_flush(i_flush),
    .o_mem_req_valid(o_mem_req_valid), .o_mem_req_addr(o_mem_req_addr),
    .i_mem_req_ready(i_mem_req_ready), .i_mem_rsp_valid(i_mem_rsp_valid),
    .i_mem_rsp_data(i_mem_rsp_data)
  );

  always #5 i_clk = ~i_clk;

  // Backing-memory contents: each word carries its own low address bits.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {16'hA5C3, addr[15:2], 2'b00};
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] addr);
    return {addr[31:4], 4'h0};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Drives one refill starting in MEM_REQ; optional stall and flush-on-beat.
  task automatic applyStimulus(input logic [31:0] addr, input int stall, input int flush_beat);
    checkOutput("mem_req_valid", 32'(o_mem_req_valid), 32'd1);
    checkOutput("mem_req_addr", o_mem_req_addr, line_of(addr));
    checkOutput("ready_in_mem_req", 32'(o_req_ready), 32'd0);
    for (int s = 0; s < stall; s++) begin
      step();
      checkOutput("stall_mem_valid", 32'(o_mem_req_valid), 32'd1);
      checkOutput("stall_mem_addr", o_mem_req_addr, line_of(addr));
      checkOutput("stall_req_ready", 32'(o_req_ready), 32'd0);
      checkOutput("stall_rsp_valid", 32'(o_rsp_valid), 32'd0);
    end
    i_mem_req_ready = 1'b1;
    step();
    i_mem_req_ready = 1'b0;
    checkOutput("refill_mem_valid_low", 32'(o_mem_req_valid), 32'd0);
    for (int b = 0; b < 4; b++) begin
      i_mem_rsp_valid = 1'b1;
      i_mem_rsp_data  = mem_word(line_of(addr) + 32'(4 * b));
      i_flush         = (b == flush_beat);
      step();
      i_mem_rsp_valid = 1'b0;
      i_flush         = 1'b0;
    end
  endtask

  // Full miss sequence ending with the hit response; leaves the cache in IDLE.
  task automatic fetch_miss(input logic [31:0] addr, input int stall, input int flush_beat);
    i_req_valid = 1'b1;
    i_req_addr  = addr;
    step();
    i_req_valid = 1'b0;
    checkOutput("miss_rsp_valid", 32'(o_rsp_valid), 32'd0);
    checkOutput("miss_rsp_instr", o_rsp_instr, 32'd0);
    step();
    applyStimulus(addr, stall, flush_beat);
    if (flush_beat >= 0) begin
      checkOutput("post_flush_miss", 32'(o_rsp_valid), 32'd0);
      step();
      applyStimulus(addr, 0, -1);
    end
    checkOutput("fill_hit_valid", 32'(o_rsp_valid), 32'd1);
    checkOutput("fill_hit_instr", o_rsp_instr, mem_word(addr));
    checkOutput("fill_hit_ready", 32'(o_req_ready), 32'd1);
    step();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_reset = 1'b1; i_req_valid = 1'b0; i_req_addr = '0; i_flush = 1'b0;
    i_mem_req_ready = 1'b0; i_mem_rsp_valid = 1'b0; i_mem_rsp_data = '0;
    repeat (3) step();
    checkOutput("reset_req_ready", 32'(o_req_ready), 32'd0);
    checkOutput("reset_rsp_valid", 32'(o_rsp_valid), 32'd0);
    checkOutput("reset_mem_valid", 32'(o_mem_req_valid), 32'd0);
    i_reset = 1'b0;
    #1;
    checkOutput("post_reset_ready", 32'(o_req_ready), 32'd1);

    // Cold miss on 0x104
    fetch_miss(32'h0000_0104, 0, -1);

    // Streaming hits across the filled line
    for (int w = 0; w < 4; w++) begin
      i_req_valid = 1'b1;
      i_req_addr  = 32'h0000_0100 + 32'(4 * w);
      step();
      checkOutput("stream_valid", 32'(o_rsp_valid), 32'd1);
      checkOutput("stream_instr", o_rsp_instr, mem_word(32'h0000_0100 + 32'(4 * w)));
      checkOutput("stream_ready", 32'(o_req_ready), 32'd1);
    end
    i_req_valid = 1'b0;
    step();

    // Conflict eviction on index 0x10, then the old line misses again
    fetch_miss(32'h0000_0500, 0, -1);
    fetch_miss(32'h0000_0100, 0, -1);

    // Memory back-pressure
    fetch_miss(32'h0000_0208, 5, -1);

    // Flush pulsed on beat 2 forces a second refill of the same line
    fetch_miss(32'h0000_030C, 0, 2);

    // Flush during a hit: that lookup still hits, the next one misses
    i_req_valid = 1'b1;
    i_req_addr  = 32'h0000_0304;
    step();
    i_req_valid = 1'b0;
    i_flush     = 1'b1;
    checkOutput("flush_lookup_valid", 32'(o_rsp_valid), 32'd1);
    checkOutput("flush_lookup_instr", o_rsp_instr, mem_word(32'h0000_0304));
    step();
    i_flush = 1'b0;
    fetch_miss(32'h0000_0304, 0, -1);

    // Reset after beat 1 of a refill of 0x100
    i_req_valid = 1'b1;
    i_req_addr  = 32'h0000_0100;
    step();
    i_req_valid = 1'b0;
    checkOutput("pre_reset_miss", 32'(o_rsp_valid), 32'd0);
    step();
    i_mem_req_ready = 1'b1;
    step();
    i_mem_req_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      i_mem_rsp_valid = 1'b1;
      i_mem_rsp_data  = mem_word(32'h0000_0100 + 32'(4 * b));
      step();
    end
    i_mem_rsp_valid = 1'b0;
    i_reset = 1'b1;
    #1;
    checkOutput("midreset_ready", 32'(o_req_ready), 32'd0);
    checkOutput("midreset_mem_valid", 32'(o_mem_req_valid), 32'd0);
    step();
    i_reset = 1'b0;
    #1;
    checkOutput("after_midreset_ready", 32'(o_req_ready), 32'd1);
    for (int b = 0; b < 2; b++) begin
      i_mem_rsp_valid = 1'b1;
      i_mem_rsp_data  = 32'hDEAD_0000 + 32'(b);
      step();
      checkOutput("stray_beat_idle", 32'(o_req_ready), 32'd1);
      checkOutput("stray_beat_rsp", 32'(o_rsp_valid), 32'd0);
    end
    i_mem_rsp_valid = 1'b0;
    fetch_miss(32'h0000_0100, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
